kiwi_button_reader: RTL and testbench

Input-side companion to the LED output path: samples the Kiwi board's active-low pushbuttons on CLK_50, synchronises and debounces each one independently, and presents clean active-high levels plus single-cycle press, release and long-press events to downstream user logic. Sits directly between the top-level button pins and any application state machine.

---
 rtl/kiwi_pkg.sv | 22 ++
 rtl/kiwi_sync2.sv | 35 +++
 rtl/kiwi_button_reader.sv | 196 +++++++++++++++++++
 tb/tb_kiwi_button_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kiwi_pkg.sv
// kiwi_pkg: definitions shared by the Kiwi pushbutton input path.
//   KEY_ACTIVE_LEVEL : pin level that means "pressed" on this board
//   btn_state_e      : per-button debounce FSM state
//   ms_to_cycles()   : converts a millisecond duration into clock cycles
package kiwi_pkg;

    // Kiwi pushbuttons pull the pin low when pressed.
    localparam logic KEY_ACTIVE_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PEND_PRESS   = 2'd1,
        ST_HELD         = 2'd2,
        ST_PEND_RELEASE = 2'd3
    } btn_state_e;

    // Dividing first keeps the product inside 32 bits for realistic clocks.
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/kiwi_sync2.sv
// kiwi_sync2: two-flop synchroniser, one independent chain per bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages to 0
//   d     : asynchronous input bits
//   q     : synchronised output bits (two-cycle latency)
module kiwi_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/kiwi_button_reader.sv
// kiwi_button_reader: synchronises and debounces the Kiwi pushbuttons and
// reports clean active-high levels plus single-cycle press/release/long events.
//   CLK_50      : system clock, all logic on the rising edge
//   RESET_N     : asynchronous active-low reset, release synchronised internally
//   KEY_N       : raw button pins, 0 = pressed, asynchronous
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle pulse on an accepted press
//   key_release : one-cycle pulse on an accepted release
//   key_long    : one-cycle pulse once a press has been held LONG_MS
// Build option: define LONG_PRESS_EN to build the hold counters and key_long;
// without it key_long is tied low and LONG_MS has no effect.
module kiwi_button_reader
    import kiwi_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int NUM_KEYS    = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic                CLK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY_N,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int DB_W      = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_db_check
        $error("kiwi_button_reader: debounce window must be at least 2 cycles");
    end
    if (LONG_MS < 0) begin : g_long_check
        $error("kiwi_button_reader: LONG_MS must not be negative");
    end

    // Reset asserts asynchronously but is released two edges later so every
    // flop leaves reset on the same clock.
    logic rst_n_sync;

    kiwi_sync2 #(.WIDTH(1)) u_rst_sync (
        .clk   (CLK_50),
        .rst_n (RESET_N),
        .d     (1'b1),
        .q     (rst_n_sync)
    );

    logic [NUM_KEYS-1:0] key_act;
    logic [NUM_KEYS-1:0] key_s;

    genvar gi;
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_act
        assign key_act[gi] = (KEY_N[gi] == KEY_ACTIVE_LEVEL);
    end

    kiwi_sync2 #(.WIDTH(NUM_KEYS)) u_key_sync (
        .clk   (CLK_50),
        .rst_n (rst_n_sync),
        .d     (key_act),
        .q     (key_s)
    );

    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        btn_state_e      state_q, state_d;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            s;

        assign s = key_s[gi];

        // State register
        always_ff @(posedge CLK_50 or negedge rst_n_sync) begin
            if (!rst_n_sync) begin
                state_q   <= ST_IDLE;
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Next state: db_cnt counts consecutive samples that disagree with
        // the accepted level; any agreeing sample abandons the change.
        always_comb begin
            state_d  = state_q;
            db_cnt_d = db_cnt_q;
            unique case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        state_d  = ST_PEND_PRESS;
                        db_cnt_d = DB_W'(1);
                    end
                end
                ST_PEND_PRESS: begin
                    if (!s) begin
                        state_d  = ST_IDLE;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d  = ST_HELD;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_d  = ST_PEND_RELEASE;
                        db_cnt_d = DB_W'(1);
                    end
                end
                ST_PEND_RELEASE: begin
                    if (s) begin
                        state_d  = ST_HELD;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d  = ST_IDLE;
                        db_cnt_d = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end
            endcase
        end

        // Outputs: events fire on the cycle a pending change is accepted and
        // are registered so nothing reaches the ports combinationally.
        always_comb begin
            press_d   = (state_q == ST_PEND_PRESS)   &&  s && (db_cnt_q == DB_LAST);
            release_d = (state_q == ST_PEND_RELEASE) && !s && (db_cnt_q == DB_LAST);
            level_d   = level_q;
            if (press_d) begin
                level_d = 1'b1;
            end else if (release_d) begin
                level_d = 1'b0;
            end
        end

        assign key_level[gi]   = level_q;
        assign key_press[gi]   = press_q;
        assign key_release[gi] = release_q;

`ifdef LONG_PRESS_EN
        localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
        localparam int LONG_W      = $clog2(LONG_CYCLES + 1);
        localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
        localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

        logic [LONG_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;

        // The hold time keeps running through a pending release so a short
        // glitch does not restart it; saturation stops key_long re-firing.
        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (release_d) begin
                hold_d = '0;
            end else if (((state_q == ST_HELD) || (state_q == ST_PEND_RELEASE)) &&
                         (hold_q != LONG_MAX)) begin
                hold_d = hold_q + 1'b1;
                long_d = (hold_q == LONG_LAST);
            end
        end

        always_ff @(posedge CLK_50 or negedge rst_n_sync) begin
            if (!rst_n_sync) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign key_long[gi] = long_q;
`else
        assign key_long[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_kiwi_button_reader.sv
module tb_kiwi_button_reader;

    localparam int NK    = 4;
    localparam int DB    = 10;  // 10 kHz clock, 1 ms debounce
    localparam int LONGC = 50;  // 5 ms long press
`ifdef LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] KEY_N = '1;
    logic [NK-1:0] key_level, key_press, key_release, key_long;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kiwi_button_reader #(
        .CLK_HZ      (10000),
        .NUM_KEYS    (NK),
        .DEBOUNCE_MS (1),
        .LONG_MS     (5)
    ) dut (
        .CLK_50      (clk),
        .RESET_N     (rst_n),
        .KEY_N       (KEY_N),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level change is accepted once the synchronised
    // input has disagreed with the accepted level for DB consecutive edges;
    // a long event fires LONGC edges after the press unless released first.
    int            cyc = 0;
    int            m_rcnt = 0;
    logic [NK-1:0] m_sync1 = '0, m_s = '0;
    logic [NK-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
    int            m_run[NK];
    int            m_press_cyc[NK];
    bit            m_armed[NK];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rcnt  = 0;
            m_sync1 = '0;
            m_s     = '0;
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            m_long  = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k]   = 0;
                m_armed[k] = 1'b0;
            end
        end else begin
            cyc++;
            if (m_rcnt < 2) begin
                m_rcnt++;
            end else begin
                m_press = '0;
                m_rel   = '0;
                m_long  = '0;
                for (int k = 0; k < NK; k++) begin
                    if (m_s[k] != m_level[k]) m_run[k]++;
                    else                      m_run[k] = 0;
                    if (m_run[k] == DB) begin
                        m_run[k]   = 0;
                        m_level[k] = ~m_level[k];
                        if (m_level[k]) begin
                            m_press[k]     = 1'b1;
                            m_press_cyc[k] = cyc;
                            m_armed[k]     = 1'b1;
                        end else begin
                            m_rel[k]   = 1'b1;
                            m_armed[k] = 1'b0;
                        end
                    end else if (m_level[k] && m_armed[k] && (cyc - m_press_cyc[k] == LONGC)) begin
                        m_armed[k] = 1'b0;
                        m_long[k]  = LONG_EN;
                    end
                end
                m_s     = m_sync1;
                m_sync1 = ~KEY_N;
            end
        end
    end

    always @(negedge clk) begin
        check("model_level",   key_level,   m_level);
        check("model_press",   key_press,   m_press);
        check("model_release", key_release, m_rel);
        check("model_long",    key_long,    m_long);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n_pulse, off, n_long;
    int dur[NK];

    initial begin
        // Reset state
        tick(3);
        check("rst_level", key_level, '0);
        check("rst_press", key_press, '0);
        check("rst_long",  key_long,  '0);
        rst_n = 1'b1;
        tick(6);

        // Clean press and release on key 0
        KEY_N[0] = 1'b0;
        tick(11);
        check("clean_press_early", key_press, 4'b0000);
        tick(1);
        check("clean_press_e12", key_press, 4'b0001);
        check("clean_level_e12", key_level, 4'b0001);
        tick(1);
        check("clean_press_width", key_press, 4'b0000);
        tick(5);
        KEY_N[0] = 1'b1;
        tick(11);
        check("clean_release_early", key_release, 4'b0000);
        tick(1);
        check("clean_release_e12", key_release, 4'b0001);
        check("clean_level_off", key_level, 4'b0000);
        tick(3);

        // Bounce on key 1: toggle every 3 cycles, ending low
        n_pulse = 0;
        for (int t = 0; t <= 30; t++) begin
            if (t % 3 == 0) KEY_N[1] = ~KEY_N[1];
            if (t < 30) begin
                tick(1);
                if (key_press[1] || key_release[1]) n_pulse++;
            end
        end
        for (int t = 0; t < 11; t++) begin
            tick(1);
            if (key_press[1] || key_release[1]) n_pulse++;
        end
        check_int("bounce_no_pulses", n_pulse, 0);
        tick(1);
        check("bounce_press_e12", key_press, 4'b0010);
        tick(3);

        // Long press on key 2, held 100 cycles
        KEY_N[2] = 1'b0;
        tick(12);
        check("long_press_e12", key_press, 4'b0100);
        n_long = 0;
        off = -1;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (key_long[2]) begin
                n_long++;
                off = i;
            end
        end
`ifdef LONG_PRESS_EN
        check_int("long_count", n_long, 1);
        check_int("long_offset", off, LONGC);
`else
        check_int("long_count_disabled", n_long, 0);
`endif
        KEY_N[2] = 1'b1;
        tick(14);

        // Simultaneous press on keys 0 and 3, then a release glitch on key 3
        KEY_N[0] = 1'b0;
        KEY_N[3] = 1'b0;
        tick(12);
        check("simul_press", key_press, 4'b1001);
        tick(20);
        n_pulse = 0;
        KEY_N[3] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) KEY_N[3] = 1'b0;
            tick(1);
            if (key_release[3]) n_pulse++;
        end
        check_int("glitch_no_release", n_pulse, 0);
        check("glitch_level", key_level, 4'b1011);
        KEY_N[0] = 1'b1;
        KEY_N[3] = 1'b1;
        tick(14);

        // Reset mid-debounce with key 1 still held
        KEY_N[0] = 1'b0;
        tick(8);
        check("pre_reset_level", key_level, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("reset_async_level", key_level, 4'b0000);
        check("reset_async_press", key_press | key_release | key_long, 4'b0000);
        tick(3);
        rst_n = 1'b1;
        tick(13);
        check("post_reset_early", key_press, 4'b0000);
        tick(1);
        check("post_reset_press", key_press, 4'b0011);
        check("post_reset_level", key_level, 4'b0011);

        // Randomised phase, including one reset in the middle
        KEY_N = '1;
        tick(20);
        for (int k = 0; k < NK; k++) dur[k] = int'($urandom_range(1, 40));
        for (int t = 0; t < 4000; t++) begin
            if (t == 2000) rst_n = 1'b0;
            if (t == 2003) rst_n = 1'b1;
            for (int k = 0; k < NK; k++) begin
                dur[k]--;
                if (dur[k] <= 0) begin
                    KEY_N[k] = ~KEY_N[k];
                    if ($urandom_range(0, 1) == 1) dur[k] = int'($urandom_range(1, 9));
                    else                           dur[k] = int'($urandom_range(10, 70));
                end
            end
            tick(1);
        end
        KEY_N = '1;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
